data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//   Responder end of the CPU data-memory interface: accepts load/store requests from the CPU
//   over a valid/ready handshake and services them from an internal word-organised RAM.
//   Applies byte/halfword/word store lane merging and checks alignment and range.
//   Returns each response after a programmable number of wait states.
//   Sits between the CPU memory stage and the data RAM, and replaces direct array access.
// PARAMETERS
//   ADDR_WIDTH   9   word-address width; RAM depth = 2**ADDR_WIDTH 32-bit words (default 512)
//   WAIT_STATES  2   extra cycles between request acceptance and response (0..15)
// PORTS
//   clock       in   1           single clock, rising edge
//   reset       in   1           asynchronous, active-low (0 = in reset)
//   req_valid   in   1           CPU presents a request
//   req_ready   out  1           responder can accept a request this cycle
//   req_write   in   1           1 = store, 0 = load
//   req_size    in   2           00 byte, 01 halfword, 10 word, 11 illegal
//   req_addr    in   32          byte address
//   req_wdata   in   32          store data, right-justified (byte in [7:0], half in [15:0])
//   resp_valid  out  1           response available
//   resp_ready  in   1           CPU consumes the response
//   resp_rdata  out  32          full aligned word at the addressed word (loads); 0 for stores/errors
//   resp_error  out  1           request was misaligned, out of range or illegal size
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0,
//     wait counter=0, captured request cleared. RAM contents are not cleared.
//     req_ready rises on the first clock edge after reset deasserts.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//     IDLE: req_ready=1. Request accepted on an edge with req_valid&&req_ready. All req_* fields
//       are captured and counter=WAIT_STATES. Next state is WAIT, or RESP if WAIT_STATES==0.
//     WAIT: req_ready=0. Counter decrements each edge; the edge at which counter==1 enters RESP.
//     RESP: req_ready=0, resp_valid=1. rdata and error are held stable until resp_ready=1.
//       On the edge with resp_valid&&resp_ready, go to IDLE and drop resp_valid.
//   Latency: resp_valid is high exactly WAIT_STATES+1 cycles after the accepting edge.
//     Minimum one request per WAIT_STATES+2 cycles; there is no overlap or pipelining.
//   Error check at capture: error if req_size==11, OR size==01 with addr[0]!=0,
//     OR size==10 with addr[1:0]!=0, OR addr[31:ADDR_WIDTH+2]!=0.
//   Store commit: the write to RAM occurs on the edge that enters RESP, only if no error.
//     Lanes are merged into the word at addr[ADDR_WIDTH+1:2]:
//     - byte: wdata[7:0] -> lane addr[1:0]
//     - half: wdata[15:0] -> lanes {addr[1],1},{addr[1],0}
//     - word: all 4 lanes
//     Unwritten lanes are preserved.
//   Load: resp_rdata = RAM word at addr[ADDR_WIDTH+1:2], sampled on the edge entering RESP.
//     The CPU performs byte/half extraction and sign extension.
//   Error response: no RAM change, resp_rdata=0, resp_error=1; stores respond with rdata=0.
//   req_valid while not in IDLE is ignored and not queued. The CPU must hold the request until accepted.
//   Reset mid-operation: a request in WAIT is discarded and its store is NOT committed.
//     A response pending in RESP is lost and resp_valid drops immediately.
//   Address wrap: none. Out-of-range addresses error; they do not alias.
// TESTING  (WAIT_STATES=2, ADDR_WIDTH=9)
//   1. Store word 0xDEADBEEF @0x10, then load @0x10 -> rdata=0xDEADBEEF, error=0;
//      resp_valid 3 cycles after each accept.
//   2. Store word 0x11223344 @0x20, store byte 0xAA @0x21, load @0x20 -> rdata=0x1122AA44.
//   3. Store half 0xBEEF @0x23 -> resp_error=1, rdata=0; a subsequent load @0x20 is unchanged.
//   4. Load @0x800 (word 512, out of range) -> error=1. Load with req_size=11 @0x0 -> error=1.
//   5. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0;
//      accept on the first resp_ready=1 cycle.
//   6. Store 0xCAFEF00D @0x40 with reset pulsed low during WAIT -> outputs reset asynchronously;
//      load @0x40 returns the prior value.

Source files
------------

// File: rtl/data_memory_responder.sv
// Responder end of the CPU data-memory interface: valid/ready request capture, programmable
// wait states, byte/half/word store merging into an internal word RAM, and error checking.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, next_state;

  logic [3:0]            wait_count;
  logic                  out_of_reset;
  logic                  cap_write;
  logic [1:0]            cap_size;
  logic [31:0]           cap_addr;
  logic [31:0]           cap_wdata;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  eff_write;
  logic [1:0]            eff_size;
  logic [31:0]           eff_addr;
  logic [31:0]           eff_wdata;
  logic                  eff_error;
  logic [ADDR_WIDTH-1:0] eff_index;
  logic [3:0]            lane_enable;
  logic [31:0]           lane_data;

  // req_ready is held low until the first edge after reset releases
  assign req_ready  = (state == IDLE) && out_of_reset;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // With zero wait states the RESP-entering edge is the accepting edge, so the live request is used
  always_comb begin
    eff_write = cap_write;
    eff_size  = cap_size;
    eff_addr  = cap_addr;
    eff_wdata = cap_wdata;
    if (state == IDLE) begin
      eff_write = req_write;
      eff_size  = req_size;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
    end
  end

  always_comb begin
    eff_error = 1'b0;
    if (eff_size == 2'b11)
      eff_error = 1'b1;
    if (eff_size == 2'b01 && eff_addr[0] != 1'b0)
      eff_error = 1'b1;
    if (eff_size == 2'b10 && eff_addr[1:0] != 2'b00)
      eff_error = 1'b1;
    if (eff_addr[31:ADDR_WIDTH+2] != '0)
      eff_error = 1'b1;
  end

  assign eff_index = eff_addr[ADDR_WIDTH+1:2];

  always_comb begin
    lane_enable = 4'b1111;
    lane_data   = eff_wdata;
    case (eff_size)
      2'b00: begin
        lane_enable = 4'b0001 << eff_addr[1:0];
        lane_data   = {4{eff_wdata[7:0]}};
      end
      2'b01: begin
        lane_enable = eff_addr[1] ? 4'b1100 : 4'b0011;
        lane_data   = {2{eff_wdata[15:0]}};
      end
      default: begin
        lane_enable = 4'b1111;
        lane_data   = eff_wdata;
      end
    endcase
  end

  always_comb begin
    enter_resp = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          enter_resp = (WAIT_STATES == 0);
          next_state = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_count == 4'd1) begin
          enter_resp = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      out_of_reset <= 1'b0;
      wait_count   <= 4'd0;
      cap_write    <= 1'b0;
      cap_size     <= 2'b00;
      cap_addr     <= 32'd0;
      cap_wdata    <= 32'd0;
      resp_rdata   <= 32'd0;
      resp_error   <= 1'b0;
    end else begin
      state        <= next_state;
      out_of_reset <= 1'b1;
      if (accept) begin
        cap_write  <= req_write;
        cap_size   <= req_size;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
        wait_count <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        wait_count <= wait_count - 4'd1;
      end
      // Loads see the word as it stood before this edge; stores and errors return zero
      if (enter_resp) begin
        resp_error <= eff_error;
        if (!eff_write && !eff_error)
          resp_rdata <= mem[eff_index];
        else
          resp_rdata <= 32'd0;
      end
    end
  end

  // RAM has no reset; only error-free stores reaching RESP touch it
  always_ff @(posedge clock) begin
    if (enter_resp && eff_write && !eff_error) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (lane_enable[lane])
          mem[eff_index][lane*8 +: 8] <= lane_data[lane*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed, table-driven bench for data_memory_responder with hand-written sequences for
// response back-pressure and reset during WAIT and RESP.
module tb_data_memory_responder;

  localparam int WS = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
  } vec_t;

  vec_t vecs[19];

  data_memory_responder #(.ADDR_WIDTH(9), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Drive one request and return just after the accepting edge
  task automatic sendRequest(input vec_t v, input string name);
    int n = 0;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = v.write;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  // Count negedges after the accepting edge until resp_valid shows
  task automatic waitResponse(input string name);
    int lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!resp_valid && lat < 20);
    checkOutput({name, " latency"}, 32'(lat), 32'(WS + 1));
  endtask

  task automatic applyStimulus(input vec_t v, input string name, input int hold);
    logic [31:0] held;
    sendRequest(v, name);
    waitResponse(name);
    checkOutput({name, " rdata"}, resp_rdata, v.rdata);
    checkOutput({name, " error"}, 32'(resp_error), 32'(v.error));
    checkOutput({name, " busy"}, 32'(req_ready), 32'd0);
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checkOutput($sformatf("%s hold%0d valid", name, i), 32'(resp_valid), 32'd1);
      checkOutput($sformatf("%s hold%0d rdata", name, i), resp_rdata, held);
      checkOutput($sformatf("%s hold%0d ready", name, i), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    checkOutput({name, " drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 2'b10, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 32'h0000_0021, 32'h0000_00AA, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 32'h0000_0020, 32'h0,         32'h1122_AA44, 1'b0};
    vecs[5]  = '{1'b1, 2'b01, 32'h0000_0023, 32'h0000_BEEF, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 2'b10, 32'h0000_0020, 32'h0,         32'h1122_AA44, 1'b0};
    vecs[7]  = '{1'b0, 2'b10, 32'h0000_0800, 32'h0,         32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 2'b11, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 2'b01, 32'h0000_0022, 32'h0000_5566, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 32'h0000_0020, 32'h0,         32'h5566_AA44, 1'b0};
    vecs[11] = '{1'b1, 2'b10, 32'h0000_07FC, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b1, 2'b00, 32'h0000_07FF, 32'h0000_0077, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b0, 2'b10, 32'h0000_07FC, 32'h0,         32'h7700_0000, 1'b0};
    vecs[14] = '{1'b0, 2'b10, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 2'b00, 32'h8000_0041, 32'h0,         32'h0000_0000, 1'b1};
    vecs[16] = '{1'b0, 2'b00, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[17] = '{1'b1, 2'b10, 32'h0000_1010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[18] = '{1'b1, 2'b10, 32'h0000_0040, 32'h0102_0304, 32'h0000_0000, 1'b0};

    // Reset state while held in reset, then req_ready rises on the first edge after release
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset resp_error", 32'(resp_error), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 checkOutput("release ready low", 32'(req_ready), 32'd0);
    @(posedge clock);
    #1 checkOutput("release ready high", 32'(req_ready), 32'd1);

    for (int i = 0; i < 19; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i), 0);

    // Back-pressure: response held for five cycles with resp_ready low
    v = '{1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};
    applyStimulus(v, "hold", 5);

    // Reset during WAIT discards the pending store
    v = '{1'b1, 2'b10, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 1'b0};
    sendRequest(v, "rstwait");
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rstwait resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rstwait req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    v = '{1'b0, 2'b10, 32'h0000_0040, 32'h0, 32'h0102_0304, 1'b0};
    applyStimulus(v, "rstwait load", 0);

    // Reset during RESP drops the error response immediately
    v = '{1'b0, 2'b10, 32'h0000_0800, 32'h0, 32'h0, 1'b1};
    sendRequest(v, "rstresp");
    waitResponse("rstresp");
    checkOutput("rstresp pre error", 32'(resp_error), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("rstresp resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rstresp resp_error", 32'(resp_error), 32'd0);
    checkOutput("rstresp resp_rdata", resp_rdata, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    v = '{1'b0, 2'b10, 32'h0000_0020, 32'h0, 32'h5566_AA44, 1'b0};
    applyStimulus(v, "after reset load", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
